serial_adder: RTL

//  Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder_full_adder_cell.sv | 14 +
 rtl/serial_adder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The build macro SERIAL_ADDER_SUB_EN (see serial_adder.sv) needs nothing from this package.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width. A one-bit adder still keeps a one-bit counter, so the
  // width never collapses to zero.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder.
// With SERIAL_ADDER_SUB_EN defined, the bus also carries the subtract select.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// Single combinational full-adder cell, shared by every bit position of the
// serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands
// LSB first, one bit per clock, behind a start/busy/done handshake.
// Build option: define SERIAL_ADDER_SUB_EN to add the subtract select
// (a - b - cin computed as a + ~b with initial carry ~cin).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;

  logic             load;
  logic             sub_in;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  full_adder_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath: accept start in IDLE/DONE, then one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // New bit enters at the MSB so the finished word ends up LSB-aligned.
        s_sh_d  = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_sh_d;
          cout_d  = fa_co;
          // carry_q is the carry into the MSB at this point
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtraction reuses the adder: invert b and the incoming carry.
    if (load) begin
      a_sh_d  = bus.a;
      b_sh_d  = sub_in ? ~bus.b : bus.b;
      carry_d = bus.cin ^ sub_in;
      cnt_d   = '0;
    end
  end

  // Control state and visible results, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand and partial-sum shift registers; always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    s_sh_q <= s_sh_d;
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
